// File: rtl/mem_store_monitor.sv
// Checks a DUT's store stream against an in-order table of expected (address, data) pairs.
// Reports PASS, a first-mismatch FAIL with the offending store captured, or a timeout.
module mem_store_monitor #(
    parameter int          XLEN        = 32,
    parameter int          DEPTH       = 4,
    parameter int          TIMEOUT_CYC = 1000,
    parameter bit          IGN_EN      = 1'b1,
    parameter int unsigned IGN_ADDR    = 96,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             exp_we,
    input  logic [IDX_W-1:0] exp_idx,
    input  logic [XLEN-1:0]  exp_addr,
    input  logic [XLEN-1:0]  exp_data,
    input  logic [CNT_W-1:0] exp_cnt,
    input  logic             start,
    input  logic             memwrite,
    input  logic [XLEN-1:0]  dataadr,
    input  logic [XLEN-1:0]  writedata,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] match_cnt,
    output logic [XLEN-1:0]  err_addr,
    output logic [XLEN-1:0]  err_data
);
    localparam int            TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [XLEN-1:0] IGN_A = XLEN'(IGN_ADDR);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TOUT} state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] cnt_lat;
    logic [XLEN-1:0]  tbl_addr [DEPTH];
    logic [XLEN-1:0]  tbl_data [DEPTH];

    logic             ptr_ok, st_chk, hit, tmo;
    logic [CNT_W-1:0] mc_inc;
    logic [XLEN-1:0]  cur_addr, cur_data;

    // The table is deliberately left out of reset so a check can be rerun after an abort.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && exp_we && int'(exp_idx) < DEPTH) begin
            tbl_addr[exp_idx] <= exp_addr;
            tbl_data[exp_idx] <= exp_data;
        end
    end

    // match_cnt doubles as the table pointer; past the last entry nothing can match.
    always_comb begin
        ptr_ok   = int'(match_cnt) < DEPTH;
        cur_addr = '0;
        cur_data = '0;
        if (ptr_ok) begin
            cur_addr = tbl_addr[match_cnt[IDX_W-1:0]];
            cur_data = tbl_data[match_cnt[IDX_W-1:0]];
        end
        st_chk = memwrite && !(IGN_EN && dataadr == IGN_A);
        hit    = ptr_ok && dataadr == cur_addr && writedata == cur_data;
        mc_inc = match_cnt + 1'b1;
        tmo    = int'(timer) + 1 >= TIMEOUT_CYC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            timer     <= '0;
            cnt_lat   <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_code <= 2'b00;
            match_cnt <= '0;
            err_addr  <= '0;
            err_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        match_cnt <= '0;
                        timer     <= '0;
                        cnt_lat   <= exp_cnt;
                        if (exp_cnt == '0) begin
                            state <= S_PASS;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    timer <= timer + 1'b1;
                    // Written so an X on the compare falls through to the mismatch branch.
                    if (st_chk && hit) begin
                        match_cnt <= mc_inc;
                        if (mc_inc == cnt_lat) begin
                            state <= S_PASS;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else if (tmo) begin
                            state     <= S_TOUT;
                            done      <= 1'b1;
                            fail_code <= 2'b10;
                        end
                    end else if (st_chk) begin
                        state     <= S_FAIL;
                        done      <= 1'b1;
                        fail_code <= 2'b01;
                        err_addr  <= dataadr;
                        err_data  <= writedata;
                    end else if (tmo) begin
                        state     <= S_TOUT;
                        done      <= 1'b1;
                        fail_code <= 2'b10;
                    end
                end
                default: begin
                    if (start) begin
                        state     <= S_IDLE;
                        timer     <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        fail_code <= 2'b00;
                        match_cnt <= '0;
                        err_addr  <= '0;
                        err_data  <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_store_monitor.sv
// Bench for mem_store_monitor: directed scenarios plus randomized store streams
// scored against a sequence-level model of the expected verdict.
module tb_mem_store_monitor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        exp_we = 1'b0;
    logic [1:0]  exp_idx = '0;
    logic [31:0] exp_addr = '0, exp_data = '0;
    logic [2:0]  exp_cnt = '0;
    logic        start = 1'b0, memwrite = 1'b0;
    logic [31:0] dataadr = '0, writedata = '0;

    logic        done_m, pass_m, done_n, pass_n;
    logic [1:0]  fc_m, fc_n;
    logic [2:0]  mc_m, mc_n;
    logic [31:0] ea_m, ed_m, ea_n, ed_n;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] ea [4];
    logic [31:0] ed [4];
    bit          sv [$];
    logic [31:0] sa [$];
    logic [31:0] sd [$];

    always #5 clk = ~clk;

    mem_store_monitor #(.XLEN(32), .DEPTH(4), .TIMEOUT_CYC(10), .IGN_EN(1'b1), .IGN_ADDR(96)) u_main (
        .clk(clk), .rst_n(rst_n), .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr),
        .exp_data(exp_data), .exp_cnt(exp_cnt), .start(start), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata), .done(done_m), .pass(pass_m),
        .fail_code(fc_m), .match_cnt(mc_m), .err_addr(ea_m), .err_data(ed_m));

    mem_store_monitor #(.XLEN(32), .DEPTH(4), .TIMEOUT_CYC(1000), .IGN_EN(1'b0), .IGN_ADDR(96)) u_noign (
        .clk(clk), .rst_n(rst_n), .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr),
        .exp_data(exp_data), .exp_cnt(exp_cnt), .start(start), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata), .done(done_n), .pass(pass_n),
        .fail_code(fc_n), .match_cnt(mc_n), .err_addr(ea_n), .err_data(ed_n));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Verdict from the rules: walk the per-cycle stores, first non-ignored
    // store that is not the next expected pair fails; timeout on cycle tmo.
    // vc: 1 pass, 2 fail, 3 timeout. ec: RUN cycle on which the verdict lands.
    task automatic predict(input int cnt, input bit ign, input int tmo, output int vc,
                           output int mc, output logic [31:0] xa, output logic [31:0] xd,
                           output int ec);
        int m;
        m = 0; xa = '0; xd = '0; vc = 3; ec = tmo;
        if (cnt == 0) begin
            vc = 1; ec = 0; mc = 0;
            return;
        end
        for (int c = 1; c <= tmo; c++) begin
            if (c <= sv.size() && sv[c-1] && !(ign && sa[c-1] == 32'd96)) begin
                if (m < 4 && sa[c-1] == ea[m] && sd[c-1] == ed[m]) begin
                    m++;
                    if (m == cnt) begin vc = 1; ec = c; mc = m; return; end
                end else begin
                    vc = 2; ec = c; xa = sa[c-1]; xd = sd[c-1]; mc = m;
                    return;
                end
            end
        end
        mc = m;
    endtask

    task automatic clear_st();
        sv.delete(); sa.delete(); sd.delete();
    endtask

    task automatic push(input bit v, input logic [31:0] a, input logic [31:0] d);
        sv.push_back(v); sa.push_back(a); sd.push_back(d);
    endtask

    task automatic to_idle();
        if (done_m) begin
            @(negedge clk) start = 1'b1;
            @(negedge clk) start = 1'b0;
            chk("idle_done", done_m, 0);
            chk("idle_pass", pass_m, 0);
            chk("idle_fc", fc_m, 0);
            chk("idle_mc", mc_m, 0);
            chk("idle_err_addr", ea_m, 0);
        end
    endtask

    task automatic load(input int i, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        exp_we = 1'b1; exp_idx = i[1:0]; exp_addr = a; exp_data = d;
        ea[i] = a; ed[i] = d;
        @(negedge clk) exp_we = 1'b0;
    endtask

    task automatic do_run(input int cnt, input bit noise);
        int vc, mc, ec;
        logic [31:0] xa, xd;
        predict(cnt, 1'b1, 10, vc, mc, xa, xd, ec);
        to_idle();
        @(negedge clk);
        exp_cnt = 3'(cnt); start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("done_start", done_m, 32'(ec == 0));
        for (int c = 1; c <= 11; c++) begin
            if (c <= sv.size()) begin
                memwrite = sv[c-1]; dataadr = sa[c-1]; writedata = sd[c-1];
            end else begin
                memwrite = 1'b0;
            end
            if (noise) begin
                exp_we = 1'($urandom_range(0, 1)); exp_idx = 2'($urandom);
                exp_addr = $urandom; exp_data = $urandom;
                start = (c < ec) && ($urandom_range(0, 3) == 0);
            end
            @(negedge clk);
            chk($sformatf("done_c%0d", c), done_m, 32'(c >= ec));
        end
        memwrite = 1'b0; exp_we = 1'b0; start = 1'b0;
        chk("pass", pass_m, 32'(vc == 1));
        chk("fail_code", fc_m, (vc == 2) ? 32'd1 : (vc == 3) ? 32'd2 : 32'd0);
        chk("match_cnt", mc_m, 32'(mc));
        chk("err_addr", ea_m, xa);
        chk("err_data", ed_m, xd);
    endtask

    initial begin
        #12;
        chk("rst_done", done_m, 0);
        chk("rst_pass", pass_m, 0);
        chk("rst_fc", fc_m, 0);
        chk("rst_mc", mc_m, 0);
        chk("rst_err", ea_m | ed_m, 0);
        @(negedge clk) rst_n = 1'b1;

        // single entry: ignored store then match; then data mismatch
        load(0, 32'd100, 32'd25);
        clear_st(); push(1, 32'd96, 32'd7); push(1, 32'd100, 32'd25);
        do_run(1, 1'b0);
        chk("r37_pass", pass_m, 1);
        chk("r37_mc", mc_m, 1);
        clear_st(); push(1, 32'd100, 32'd24);
        do_run(1, 1'b0);
        chk("r38_err_addr", ea_m, 100);

        // timeout with no stores; final match exactly on the timeout cycle
        clear_st();
        do_run(1, 1'b0);
        chk("r39_fc", fc_m, 2);
        clear_st();
        for (int i = 0; i < 9; i++) push(0, 32'd0, 32'd0);
        push(1, 32'd100, 32'd25);
        do_run(1, 1'b0);
        chk("r39_edge_pass", pass_m, 1);

        // four entries in order, then out of order
        to_idle();
        for (int i = 0; i < 4; i++) load(i, 32'(4 * i), 32'(i + 1));
        clear_st();
        for (int i = 0; i < 4; i++) push(1, ea[i], ed[i]);
        do_run(4, 1'b0);
        clear_st();
        push(1, ea[0], ed[0]); push(1, ea[1], ed[1]); push(1, ea[3], ed[3]); push(1, ea[2], ed[2]);
        do_run(4, 1'b0);
        chk("r40_err_addr", ea_m, 12);

        // zero-length check passes immediately
        clear_st();
        do_run(0, 1'b0);

        // reset mid-run after two matches, then rerun on the retained table
        to_idle();
        @(negedge clk) exp_cnt = 3'd4; start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            memwrite = 1'b1; dataadr = ea[i]; writedata = ed[i];
            @(negedge clk);
        end
        memwrite = 1'b0;
        chk("r41_mc_pre", mc_m, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("r41_mc_rst", mc_m, 0);
        chk("r41_done_rst", done_m, 0);
        @(negedge clk) rst_n = 1'b1;
        clear_st();
        for (int i = 0; i < 4; i++) push(1, ea[i], ed[i]);
        do_run(4, 1'b0);
        chk("r41_pass", pass_m, 1);

        // filter disabled: the store to 96 is checked and fails
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        load(0, 32'd100, 32'd25);
        clear_st(); push(1, 32'd96, 32'd7);
        begin
            int vc, mc, ec;
            logic [31:0] xa, xd;
            predict(1, 1'b0, 1000, vc, mc, xa, xd, ec);
            @(negedge clk) exp_cnt = 3'd1; start = 1'b1;
            @(negedge clk) start = 1'b0; memwrite = 1'b1; dataadr = 32'd96; writedata = 32'd7;
            @(negedge clk) memwrite = 1'b0;
            chk("r42_done", done_n, 32'(vc != 1 && ec == 1));
            chk("r42_fc", fc_n, (vc == 2) ? 32'd1 : 32'd0);
            chk("r42_err_addr", ea_n, xa);
            chk("r42_err_data", ed_n, xd);
            chk("r42_main_ignored", done_m, 0);
        end
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        // randomized tables and store streams, with ignored exp_we/start noise
        for (int it = 0; it < 25; it++) begin
            int gm;
            to_idle();
            for (int i = 0; i < 4; i++)
                load(i, 32'($urandom_range(0, 40)) << 2, 32'($urandom_range(0, 3)));
            clear_st();
            gm = 0;
            for (int c = 0; c < 10; c++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5: begin
                        if (gm < 4) begin push(1, ea[gm], ed[gm]); gm++; end
                        else push(1, $urandom, $urandom);
                    end
                    7:       push(1, 32'd96, 32'($urandom_range(0, 3)));
                    8:       push(1, (gm < 4) ? ea[gm] : 32'd0, (gm < 4) ? ~ed[gm] : 32'd5);
                    default: push(0, 32'd0, 32'd0);
                endcase
            end
            do_run($urandom_range(0, 5), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
